// File: rtl/final_ctrl_pkg.sv
// Shared types and constants for the North/East traffic-light sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package final_ctrl_pkg;

  // Phase states; ALLRED_EN is the reset/home state.
  typedef enum logic [2:0] {
    ALLRED_EN = 3'd0,
    N_GREEN   = 3'd1,
    N_YELLOW  = 3'd2,
    ALLRED_NE = 3'd3,
    E_GREEN   = 3'd4,
    E_YELLOW  = 3'd5
  } state_t;

  // IC capture select codes seen by the datapath.
  localparam int         IC_W      = 2;
  localparam logic [1:0] IC_CLR    = 2'b00;  // clear IC
  localparam logic [1:0] IC_DEMAND = 2'b10;  // east demand: L & C
  localparam logic [1:0] IC_GAP    = 2'b11;  // east gap:    L | ~C

  // Light patterns, bit order {NR, NG, NY, ER, EG, EY}.
  localparam logic [5:0] PAT_ALLRED   = 6'b100_100;
  localparam logic [5:0] PAT_N_GREEN  = 6'b010_100;
  localparam logic [5:0] PAT_N_YELLOW = 6'b001_100;
  localparam logic [5:0] PAT_E_GREEN  = 6'b100_010;
  localparam logic [5:0] PAT_E_YELLOW = 6'b100_001;

  function automatic logic [5:0] state_pattern(state_t s);
    case (s)
      N_GREEN:  return PAT_N_GREEN;
      N_YELLOW: return PAT_N_YELLOW;
      E_GREEN:  return PAT_E_GREEN;
      E_YELLOW: return PAT_E_YELLOW;
      default:  return PAT_ALLRED;
    endcase
  endfunction

  function automatic logic is_green(state_t s);
    return (s == N_GREEN) || (s == E_GREEN);
  endfunction

endpackage

// File: rtl/final_ctrl_if.sv
// Control/status bundle between the sequencer and the light datapath.
// Latency: n/a (wires only).
// Backpressure: none; status is level-sampled, controls are load strobes.
// master: sequencer (drives s_*/en_*, s_IC/en_IC; reads not_r, en_s, ic)
// slave:  datapath  (the reverse)
interface final_ctrl_if;
  logic                           not_r;
  logic                           en_s;
  logic                           ic;
  logic                           s_NR, s_NG, s_NY, s_ER, s_EG, s_EY;
  logic                           en_NR, en_NG, en_NY, en_ER, en_EG, en_EY;
  logic [final_ctrl_pkg::IC_W-1:0] s_IC;
  logic                           en_IC;

  modport master (
    input  not_r, en_s, ic,
    output s_NR, s_NG, s_NY, s_ER, s_EG, s_EY,
    output en_NR, en_NG, en_NY, en_ER, en_EG, en_EY,
    output s_IC, en_IC
  );

  modport slave (
    output not_r, en_s, ic,
    input  s_NR, s_NG, s_NY, s_ER, s_EG, s_EY,
    input  en_NR, en_NG, en_NY, en_ER, en_EG, en_EY,
    input  s_IC, en_IC
  );
endinterface

// File: rtl/final_phase_timer.sv
// Phase cycle counter with clear/increment and a terminal-count compare.
// Latency: cnt updates one cycle after clr/inc; at_limit is combinational on cnt.
// Backpressure: none; inc low holds the count.
// Ports: clk, rst (sync, active high), clr, inc, limit -> cnt, at_limit.
module final_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/final_ctrl.sv
// Traffic-light sequencer: drives light/IC load strobes for the N/E datapath.
// Latency: outputs registered; en_* pulse in the first cycle of each phase,
//          datapath lights follow one cycle later. Backpressure: none;
//          not_r low forces yellow from green and freezes all-red.
// Ports: clk, rst (sync, active high), bus (final_ctrl_if.master).
// Option: define FINAL_CTRL_EASTSKIP_EN to let north rest in green with no
//         east demand instead of cycling at GREEN_MAX.
module final_ctrl
  import final_ctrl_pkg::*;
#(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  final_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_T - 1);

  state_t           state, nxt;
  logic             armed;
  logic [CNT_W-1:0] cnt, limit;
  logic             at_limit, tmr_clr, tmr_inc, enter;
  logic [5:0]       light_s, light_en;
  logic [1:0]       ic_sel;
  logic             ic_en;

  final_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .limit    (limit),
    .cnt      (cnt),
    .at_limit (at_limit)
  );

  always_comb begin
    nxt     = state;
    limit   = ALLRED_M1;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    enter   = 1'b0;
    case (state)
      ALLRED_EN, ALLRED_NE: begin
        limit = ALLRED_M1;
        // Unarmed or red-hold: freeze with cnt untouched.
        if (armed && bus.not_r) begin
          if (at_limit) nxt = (state == ALLRED_EN) ? N_GREEN : E_GREEN;
          else          tmr_inc = 1'b1;
        end
      end
      N_GREEN, E_GREEN: begin
        limit = GMAX_M1;
        // Hold wins over the min-green rule; ic exit and max share one transition.
        if (!bus.not_r || ((cnt >= GMIN_M1) && bus.ic)) begin
          nxt = (state == N_GREEN) ? N_YELLOW : E_YELLOW;
        end else if (at_limit) begin
`ifdef FINAL_CTRL_EASTSKIP_EN
          // No east demand at max green: restart the north window silently.
          if (state == N_GREEN) tmr_clr = 1'b1;
          else                  nxt     = E_YELLOW;
`else
          nxt = (state == N_GREEN) ? N_YELLOW : E_YELLOW;
`endif
        end else begin
          tmr_inc = 1'b1;
        end
      end
      N_YELLOW, E_YELLOW: begin
        limit = YELLOW_M1;
        if (at_limit) nxt = (state == N_YELLOW) ? ALLRED_NE : ALLRED_EN;
        else          tmr_inc = 1'b1;
      end
      default: nxt = ALLRED_EN;
    endcase
    enter   = (nxt != state);
    tmr_clr = tmr_clr | enter;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Force the (possibly unreset) datapath to all-red and clear IC.
      state    <= ALLRED_EN;
      armed    <= 1'b0;
      light_en <= '1;
      light_s  <= PAT_ALLRED;
      ic_en    <= 1'b1;
      ic_sel   <= IC_CLR;
    end else begin
      state    <= nxt;
      armed    <= armed | bus.en_s;
      light_en <= {6{enter}};
      if (enter) light_s <= state_pattern(nxt);
      // Greens re-capture IC every cycle; other phases clear it once on entry.
      ic_en    <= enter | is_green(nxt);
      ic_sel   <= (nxt == N_GREEN) ? IC_DEMAND :
                  (nxt == E_GREEN) ? IC_GAP    : IC_CLR;
    end
  end

  assign {bus.s_NR, bus.s_NG, bus.s_NY, bus.s_ER, bus.s_EG, bus.s_EY}       = light_s;
  assign {bus.en_NR, bus.en_NG, bus.en_NY, bus.en_ER, bus.en_EG, bus.en_EY} = light_en;
  assign bus.s_IC  = ic_sel;
  assign bus.en_IC = ic_en;

endmodule

// File: tb/tb_final_ctrl.sv
// Directed bench for final_ctrl: phase lengths, entry pulses, IC select, hold, reset.
module tb_final_ctrl;

  localparam logic [5:0] P_ALLRED = 6'b100100;
  localparam logic [5:0] P_NG     = 6'b010100;
  localparam logic [5:0] P_NY     = 6'b001100;
  localparam logic [5:0] P_EG     = 6'b100010;
  localparam logic [5:0] P_EY     = 6'b100001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  final_ctrl_if intf ();

  final_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  always #5 clk = ~clk;

  logic [5:0] s_all, en_all;
  assign s_all  = {intf.s_NR, intf.s_NG, intf.s_NY, intf.s_ER, intf.s_EG, intf.s_EY};
  assign en_all = {intf.en_NR, intf.en_NG, intf.en_NY, intf.en_ER, intf.en_EG, intf.en_EY};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next en_* pulse (the length of the phase just left); -1 on timeout.
  task automatic wait_pulse(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (en_all != 6'd0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int np);
    np = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (en_all != 6'd0) np++;
    end
  endtask

  task automatic test_reset_arm();
    int n;
    rst = 1'b1; intf.en_s = 1'b0; intf.not_r = 1'b1; intf.ic = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (en_all !== 6'h3f) $display("FAIL rst_en: got %b want 111111", en_all); else passed++;
    end
    checks++; if (s_all !== P_ALLRED) $display("FAIL rst_pat: got %b want %b", s_all, P_ALLRED); else passed++;
    checks++; if ({intf.en_IC, intf.s_IC} !== 3'b100) $display("FAIL rst_ic: got %b want 100", {intf.en_IC, intf.s_IC}); else passed++;
    rst = 1'b0;
    tick();
    checks++; if (en_all !== 6'h00) $display("FAIL idle_en: got %b want 000000", en_all); else passed++;
    tick();
    intf.en_s = 1'b1;
    tick();
    intf.en_s = 1'b0;
    wait_pulse(n);
    checks++; if (n !== 2) $display("FAIL arm_allred_len: got %0d want 2", n); else passed++;
    checks++; if (s_all !== P_NG) $display("FAIL ng_pat: got %b want %b", s_all, P_NG); else passed++;
    checks++; if ({intf.en_IC, intf.s_IC} !== 3'b110) $display("FAIL ng_ic: got %b want 110", {intf.en_IC, intf.s_IC}); else passed++;
    wait_pulse(n);
    checks++; if (n !== 20) $display("FAIL ng_max_len: got %0d want 20", n); else passed++;
    checks++; if (s_all !== P_NY) $display("FAIL ny_pat: got %b want %b", s_all, P_NY); else passed++;
    wait_pulse(n);
    checks++; if (n !== 3) $display("FAIL ny_len: got %0d want 3", n); else passed++;
    checks++; if (s_all !== P_ALLRED) $display("FAIL ane_pat: got %b want %b", s_all, P_ALLRED); else passed++;
    wait_pulse(n);
    checks++; if (n !== 2) $display("FAIL ane_len: got %0d want 2", n); else passed++;
    checks++; if (s_all !== P_EG) $display("FAIL eg_pat: got %b want %b", s_all, P_EG); else passed++;
    checks++; if ({intf.en_IC, intf.s_IC} !== 3'b111) $display("FAIL eg_ic: got %b want 111", {intf.en_IC, intf.s_IC}); else passed++;
  endtask

  // Entered at the E_GREEN entry cycle.
  task automatic test_east_gap();
    int n;
    tick(); tick();
    intf.ic = 1'b1;
    wait_pulse(n);
    checks++; if (n + 2 !== 8) $display("FAIL eg_gap_len: got %0d want 8", n + 2); else passed++;
    checks++; if (s_all !== P_EY) $display("FAIL ey_pat: got %b want %b", s_all, P_EY); else passed++;
    intf.ic = 1'b0;
    tick();
    checks++; if ({en_all, intf.en_IC} !== 7'd0) $display("FAIL ey_mid_en: got %b want 0000000", {en_all, intf.en_IC}); else passed++;
    wait_pulse(n);
    checks++; if (n + 1 !== 3) $display("FAIL ey_len: got %0d want 3", n + 1); else passed++;
    wait_pulse(n);
    checks++; if (n !== 2) $display("FAIL aen_len: got %0d want 2", n); else passed++;
    checks++; if (s_all !== P_NG) $display("FAIL ng2_pat: got %b want %b", s_all, P_NG); else passed++;
  endtask

  // Entered at the N_GREEN entry cycle.
  task automatic test_early_exit();
    int n;
    tick(); tick();
    intf.ic = 1'b1;
    checks++; if ({en_all, intf.en_IC, intf.s_IC} !== 9'b000000_1_10) $display("FAIL ng_mid_ic: got %b want 000000110", {en_all, intf.en_IC, intf.s_IC}); else passed++;
    wait_pulse(n);
    checks++; if (n + 2 !== 8) $display("FAIL ng_early_len: got %0d want 8", n + 2); else passed++;
    checks++; if (s_all !== P_NY) $display("FAIL ny2_pat: got %b want %b", s_all, P_NY); else passed++;
    intf.ic = 1'b0;
    wait_pulse(n);
    wait_pulse(n);
    wait_pulse(n);
    checks++; if (n !== 20) $display("FAIL eg_max_len: got %0d want 20", n); else passed++;
    wait_pulse(n);
    wait_pulse(n);
    checks++; if (s_all !== P_NG) $display("FAIL ng3_pat: got %b want %b", s_all, P_NG); else passed++;
  endtask

  // Entered at the N_GREEN entry cycle.
  task automatic test_red_hold();
    int n, np;
    tick(); tick();
    intf.not_r = 1'b0;
    wait_pulse(n);
    checks++; if (n !== 1) $display("FAIL hold_to_ny: got %0d want 1", n); else passed++;
    checks++; if (s_all !== P_NY) $display("FAIL hold_ny_pat: got %b want %b", s_all, P_NY); else passed++;
    wait_pulse(n);
    checks++; if (n !== 3) $display("FAIL hold_ny_len: got %0d want 3", n); else passed++;
    count_pulses(9, np);
    checks++; if (np !== 0) $display("FAIL hold_allred_pulses: got %0d want 0", np); else passed++;
    intf.not_r = 1'b1;
    wait_pulse(n);
    checks++; if (n !== 2) $display("FAIL hold_release_len: got %0d want 2", n); else passed++;
    checks++; if (s_all !== P_EG) $display("FAIL hold_eg_pat: got %b want %b", s_all, P_EG); else passed++;
  endtask

  // Entered at the E_GREEN entry cycle.
  task automatic test_reset_mid();
    int n, np;
    intf.ic = 1'b1;
    wait_pulse(n);
    intf.ic = 1'b0;
    checks++; if (n !== 8) $display("FAIL eg_ic0_len: got %0d want 8", n); else passed++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({en_all, s_all} !== {6'h3f, P_ALLRED}) $display("FAIL mid_rst: got %b want %b", {en_all, s_all}, {6'h3f, P_ALLRED}); else passed++;
    count_pulses(20, np);
    checks++; if (np !== 0) $display("FAIL unarmed_pulses: got %0d want 0", np); else passed++;
    intf.en_s = 1'b1;
    tick();
    intf.en_s = 1'b0;
    wait_pulse(n);
    checks++; if (n !== 2) $display("FAIL rearm_len: got %0d want 2", n); else passed++;
    checks++; if (s_all !== P_NG) $display("FAIL rearm_pat: got %b want %b", s_all, P_NG); else passed++;
  endtask

`ifdef FINAL_CTRL_EASTSKIP_EN
  // Entered at the N_GREEN entry cycle.
  task automatic test_eastskip();
    int n, np;
    intf.ic = 1'b0;
    count_pulses(70, np);
    checks++; if (np !== 0) $display("FAIL skip_pulses: got %0d want 0", np); else passed++;
    checks++; if (s_all !== P_NG) $display("FAIL skip_pat: got %b want %b", s_all, P_NG); else passed++;
    intf.ic = 1'b1;
    wait_pulse(n);
    checks++; if (n !== 1) $display("FAIL skip_exit: got %0d want 1", n); else passed++;
    checks++; if (s_all !== P_NY) $display("FAIL skip_ny_pat: got %b want %b", s_all, P_NY); else passed++;
    intf.ic = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    intf.not_r = 1'b1;
    intf.en_s  = 1'b0;
    intf.ic    = 1'b0;
    test_reset_arm();
    test_east_gap();
    test_early_exit();
    test_red_hold();
    test_reset_mid();
`ifdef FINAL_CTRL_EASTSKIP_EN
    test_eastskip();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/final_ctrl.md
Name: final_ctrl

Overview:
Sequencing FSM for the two-approach (North/East) traffic-light datapath. It drives every s_*/en_* select/enable pair, so the datapath light registers change only on phase boundaries. It selects the datapath's IC demand-capture mode and reads back IC and the datapath status outputs to pick phase lengths. It sits directly above the light datapath in the top level and is the only writer of its control inputs.

Parameters:
GREEN_MIN, 8, minimum green length in cycles, either approach
GREEN_MAX, 20, maximum green length in cycles (GREEN_MAX >= GREEN_MIN >= 1)
YELLOW_T, 3, yellow length in cycles (>= 1)
ALLRED_T, 2, all-red clearance length in cycles (>= 1)
CNT_W, 5, phase counter width; must hold GREEN_MAX-1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
not_r  input  1  datapath run status; low = red hold requested
en_s  input  1  datapath start status; arms the controller
ic  input  1  datapath IC register (registered demand/gap flag)
s_NR, s_NG, s_NY, s_ER, s_EG, s_EY  output  1 each  light value to load
en_NR, en_NG, en_NY, en_ER, en_EG, en_EY  output  1 each  light load enable
s_IC  output  2  IC capture select: 00 clear, 10 east-demand (L&C), 11 east-gap (L|~C)
en_IC  output  1  IC load enable

Behaviour:
- States: ALLRED_EN, N_GREEN, N_YELLOW, ALLRED_NE, E_GREEN, E_YELLOW. Light patterns: ALLRED_* = NR,ER; N_GREEN = NG,ER; N_YELLOW = NY,ER; E_GREEN = NR,EG; E_YELLOW = NR,EY.
- cnt (CNT_W bits) clears on every state entry and increments each cycle while in a state. It never wraps, because every state exits at or before GREEN_MAX-1.
- Cycle ring: ALLRED_EN -> N_GREEN -> N_YELLOW -> ALLRED_NE -> E_GREEN -> E_YELLOW -> ALLRED_EN.
- Green exit: leave when (cnt >= GREEN_MIN-1 and ic==1), or when cnt == GREEN_MAX-1.
  - N_GREEN: s_IC=10, en_IC=1 every cycle, so ic means an east car is waiting.
  - E_GREEN: s_IC=11, en_IC=1 every cycle, so ic means a gap on east.
- Yellow exit: leave at cnt == YELLOW_T-1. All-red exit: leave at cnt == ALLRED_T-1.
- In all non-green states: s_IC=00, en_IC=1 on the entry cycle only, which clears IC.
- Outputs are registered. All six en_* are 1 for exactly the first cycle of each state and 0 otherwise. s_* carry the new state's pattern in that cycle and hold their last value otherwise.
- Datapath lights change one cycle after state entry.
- Reset: while rst=1, state=ALLRED_EN, cnt=0, armed=0. All en_*=1 with the all-red pattern (s_NR=s_ER=1, others 0), so the unreset datapath is forced red. en_IC=1, s_IC=00.
- Arming: after reset, the controller stays in ALLRED_EN with cnt held at 0 until en_s==1 is sampled. It then sets armed and begins counting on the next cycle. armed is cleared only by rst.
- Red hold (not_r==0):
  - In a green state, the next cycle enters that approach's yellow, regardless of cnt and GREEN_MIN.
  - In yellow, timing continues normally.
  - In an all-red state, cnt is held and the controller stays until not_r==1.
- Simultaneous events:
  - Hold beats the green-exit rule.
  - rst beats everything.
  - A green-exit and GREEN_MAX in the same cycle produce a single transition.
- Reset mid-phase: the next cycle is the reset pattern. No yellow is issued.

Optional Feature:
FINAL_CTRL_EASTSKIP_EN:
- Defined: if N_GREEN reaches cnt == GREEN_MAX-1 with ic==0 and not_r==1, the controller stays in N_GREEN. cnt clears and en_* stays 0, so there is no visible change and north rests in green until east demand arrives.
- Undefined: the strict ring above is always followed.

Decomposition:
- Package final_ctrl_pkg holds:
  - state enum (3-bit encoding, ALLRED_EN = 0)
  - s_IC constants IC_CLR=2'b00, IC_DEMAND=2'b10, IC_GAP=2'b11
  - a 6-bit light-pattern constant per state
- One sub-module, final_phase_timer: the cnt register with clear/hold/increment and a terminal compare. It is instantiated once.

Test Plan:
- Reset and arm: rst=1 for 3 cycles, then en_s=1 two cycles after release, ic=0.
  - Required: en_* all 1 during rst; ALLRED_EN for 2 cycles after arming; N_GREEN entry pulse with s_NG=s_ER=1.
  - Then N_GREEN lasts 20 cycles, N_YELLOW 3, ALLRED_NE 2.
- Early exit: ic=1 from cycle 3 of N_GREEN.
  - Required: exit after cnt=7, so N_GREEN lasts 8 cycles; the N_YELLOW pulse shows s_NY=1, s_ER=1.
- East gap: in E_GREEN, ic=1 at cnt=2.
  - Required: E_GREEN ends after cnt=7 (8 cycles), not at cnt=3; E_YELLOW follows.
- Red hold: not_r=0 at N_GREEN cnt=2.
  - Required: next cycle N_YELLOW (3 cycles), then ALLRED_NE held while not_r=0.
  - not_r=1 released after 10 cycles: 2 more all-red cycles, then E_GREEN.
- Reset mid-operation: rst=1 during E_YELLOW cnt=1.
  - Required: next cycle en_*=1 all-red, state ALLRED_EN, and no progress until en_s is seen again.
- With FINAL_CTRL_EASTSKIP_EN defined, ic=0: N_GREEN persists more than 60 cycles with no en_* pulses; ic=1 then exits within 1 cycle (cnt >= 7).
